// File: rtl/seq_stage_controller_pkg.sv
// Shared definitions for the sequential stage controller: icodes, status codes and FSM states.
package seq_stage_controller_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcupd,
    StHalted
  } state_e;

  function automatic logic is_mem_icode(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IMRMOVQ) || (icode == ICALL) ||
           (icode == IRET) || (icode == IPUSHQ) || (icode == IPOPQ);
  endfunction

  function automatic logic is_reg_wr_icode(input logic [3:0] icode);
    return (icode == IRRMOVQ) || (icode == IIRMOVQ) || (icode == IMRMOVQ) ||
           (icode == IOPQ) || is_mem_icode(icode) && (icode != IRMMOVQ);
  endfunction

endpackage

// File: rtl/ack_timeout_counter.sv
// Wait counter for the memory request states; flags the last permitted cycle without an ack.
module ack_timeout_counter #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic count_i,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // count_i drops whenever the request state is left, so every entry starts from zero
  always_comb begin
    cnt_d = '0;
    if (count_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == CntW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle fetch/decode/execute/memory/writeback/PC-update sequencer with fault halting.
module seq_stage_controller
  import seq_stage_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 64
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             imem_error,
  input  logic [3:0]       icode_in,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             decode_en,
  output logic             execute_en,
  output logic             cc_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [2:0]       Stat,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [3:0]         icode_q, icode_d;
  logic [2:0]         stat_q, stat_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               wait_count;
  logic               timeout;

  always_comb begin
    state_d   = state_q;
    icode_d   = icode_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: if (Run) state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          if (imem_error) begin
            state_d = StHalted;
            stat_d  = StatAdr;
          end else if (icode_in > IPOPQ) begin
            state_d = StHalted;
            stat_d  = StatIns;
          end else if (icode_in == IHALT) begin
            state_d = StHalted;
            stat_d  = StatHlt;
          end else begin
            icode_d = icode_in;
            state_d = StDecode;
          end
        end else if (timeout) begin
          state_d = StHalted;
          stat_d  = StatAdr;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = is_mem_icode(icode_q) ? StMemory : StWriteback;
      StMemory: begin
        if (dmem_ack) begin
          state_d = dmem_error ? StHalted : StWriteback;
          if (dmem_error) stat_d = StatAdr;
        end else if (timeout) begin
          state_d = StHalted;
          stat_d  = StatAdr;
        end
      end
      StWriteback: state_d = StPcupd;
      StPcupd: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = Run ? StFetch : StIdle;
      end
      StHalted: state_d = StHalted;
    endcase
  end

  // Counting only while staying in a request state gives a fresh count on every entry
  assign wait_count = ((state_q == StFetch) && (state_d == StFetch)) ||
                      ((state_q == StMemory) && (state_d == StMemory));

  ack_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_ack_timeout_counter (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .count_i  (wait_count),
    .timeout_o(timeout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      icode_q   <= IHALT;
      stat_q    <= StatAok;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      icode_q   <= icode_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req   = (state_q == StFetch);
  assign dmem_req   = (state_q == StMemory);
  assign decode_en  = (state_q == StDecode);
  assign execute_en = (state_q == StExecute);
  assign cc_we      = (state_q == StExecute) && (icode_q == IOPQ);
  assign reg_we     = (state_q == StWriteback) && is_reg_wr_icode(icode_q);
  assign pc_we      = (state_q == StPcupd);
  assign busy       = (state_q != StIdle) && (state_q != StHalted);
  assign Stat       = stat_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench: stimulus queues per-cycle strobe vectors, a monitor compares every busy cycle.
module tb_seq_stage_controller;

  localparam int TO = 16;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Run;
  logic        imem_req, imem_ack, imem_error;
  logic [3:0]  icode_in;
  logic        dmem_req, dmem_ack, dmem_error;
  logic        decode_en, execute_en, cc_we, reg_we, pc_we;
  logic [2:0]  Stat;
  logic        busy;
  logic [63:0] retired;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_retired = '0;
  logic [6:0]  sb[$];

  seq_stage_controller #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (64)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Run       (Run),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_error(imem_error),
    .icode_in  (icode_in),
    .dmem_req  (dmem_req),
    .dmem_ack  (dmem_ack),
    .dmem_error(dmem_error),
    .decode_en (decode_en),
    .execute_en(execute_en),
    .cc_we     (cc_we),
    .reg_we    (reg_we),
    .pc_we     (pc_we),
    .Stat      (Stat),
    .busy      (busy),
    .retired   (retired)
  );

  always #5 Clk = ~Clk;

  // {imem_req, decode_en, execute_en, cc_we, dmem_req, reg_we, pc_we}
  function automatic logic [6:0] strobes();
    return {imem_req, decode_en, execute_en, cc_we, dmem_req, reg_we, pc_we};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Run = 1'b0; imem_ack = 1'b0; imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
    Reset_n = 1'b0;
    #3;
    Reset_n = 1'b1;
    exp_retired = '0;
  endtask

  // iwait/dwait >= TO means that ack never arrives
  task automatic do_instr(input logic [3:0] ic, input int iwait, input logic ierr,
                          input int dwait, input logic derr);
    logic [2:0] st;
    logic       mem, rw, dec;
    int         nf, nd;
    nf  = (iwait >= TO) ? TO : iwait + 1;
    nd  = (dwait >= TO) ? TO : dwait + 1;
    mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    rw  = ic inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    dec = (iwait < TO) && !ierr && (ic <= 4'hB) && (ic != 4'h0);
    if ((iwait >= TO) || ierr)              st = 3'd3;
    else if (ic > 4'hB)                     st = 3'd4;
    else if (ic == 4'h0)                    st = 3'd2;
    else if (mem && ((dwait >= TO) || derr)) st = 3'd3;
    else                                    st = 3'd1;

    for (int k = 0; k < nf; k++) sb.push_back(7'b100_0000);
    if (dec) begin
      sb.push_back(7'b010_0000);
      sb.push_back({2'b00, 1'b1, ic == 4'h6, 3'b000});
      if (mem) for (int k = 0; k < nd; k++) sb.push_back(7'b000_0100);
      if (st == 3'd1) begin
        sb.push_back({5'b00000, rw, 1'b0});
        sb.push_back(7'b000_0001);
      end
    end

    Run = 1'b1;
    step();
    Run = 1'b0;
    for (int k = 0; k < nf; k++) begin
      imem_ack = (k == iwait); imem_error = ierr; icode_in = ic;
      dmem_ack = 1'b1; dmem_error = 1'b1;
      step();
    end
    // Stray acks with poisoned data outside the matching request state
    imem_ack = 1'b1; imem_error = 1'b1; icode_in = 4'hC;
    if (dec) begin
      step();
      step();
      if (mem) begin
        for (int k = 0; k < nd; k++) begin
          dmem_ack = (k == dwait); dmem_error = derr;
          step();
        end
        dmem_ack = 1'b1; dmem_error = 1'b1;
      end
      if (st == 3'd1) begin
        step();
        step();
      end
    end
    imem_ack = 1'b0; imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;

    if (st == 3'd1) exp_retired++;
    else begin
      Run = 1'b1; imem_ack = 1'b1; icode_in = 4'h6; dmem_ack = 1'b1;
      repeat (3) step();
      Run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    end
    chk("queue_drained", 64'(sb.size()), 64'd0);
    chk("stat", 64'(Stat), 64'(st));
    chk("busy_after", 64'(busy), 64'd0);
    chk("retired", retired, exp_retired);
  endtask

  initial begin
    Reset_n = 1'b1; Run = 1'b0; imem_ack = 1'b0; imem_error = 1'b0;
    icode_in = 4'h0; dmem_ack = 1'b0; dmem_error = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge Clk);
          if (Reset_n) begin
            if (busy) begin
              if (sb.size() == 0) chk("unexpected_busy_cycle", 64'(strobes()), 64'h7f);
              else chk("strobes", 64'(strobes()), 64'(sb.pop_front()));
            end else begin
              chk("idle_strobes", 64'(strobes()), 64'd0);
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    #1 Reset_n = 1'b0;
    #2;
    chk("reset_stat", 64'(Stat), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_retired", retired, 64'd0);
    chk("reset_strobes", 64'(strobes()), 64'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    do_instr(4'h6, 0, 1'b0, 0, 1'b0);
    do_instr(4'hA, 0, 1'b0, 3, 1'b0);
    do_instr(4'h7, 2, 1'b0, 0, 1'b0);
    do_instr(4'h4, 0, 1'b0, 0, 1'b0);
    do_instr(4'h3, 1, 1'b0, 0, 1'b0);
    do_instr(4'hB, 0, 1'b0, 1, 1'b0);
    do_instr(4'h1, 0, 1'b0, 0, 1'b0);

    // Reset pulse while a data request is outstanding
    sb.push_back(7'b100_0000);
    sb.push_back(7'b010_0000);
    sb.push_back(7'b001_0000);
    sb.push_back(7'b000_0100);
    sb.push_back(7'b000_0100);
    Run = 1'b1;
    step();
    Run = 1'b0; imem_ack = 1'b1; icode_in = 4'h5;
    step();
    imem_ack = 1'b0;
    step();
    step();
    step();
    #5;
    chk("dmem_req_before_reset", 64'(dmem_req), 64'd1);
    Reset_n = 1'b0;
    #1;
    chk("dmem_req_async_drop", 64'(dmem_req), 64'd0);
    chk("strobes_in_reset", 64'(strobes()), 64'd0);
    chk("retired_in_reset", retired, 64'd0);
    #2 Reset_n = 1'b1;
    exp_retired = '0;
    step();
    chk("post_reset_stat", 64'(Stat), 64'd1);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_retired", retired, 64'd0);
    chk("post_reset_queue", 64'(sb.size()), 64'd0);

    do_instr(4'h5, 0, 1'b0, 0, 1'b0);

    do_instr(4'hC, 0, 1'b0, 0, 1'b0);
    do_reset();
    do_instr(4'h0, 1, 1'b0, 0, 1'b0);
    do_reset();
    do_instr(4'h6, 0, 1'b1, 0, 1'b0);
    do_reset();
    do_instr(4'h8, 0, 1'b0, TO, 1'b0);
    do_reset();
    do_instr(4'h2, TO, 1'b0, 0, 1'b0);
    do_reset();
    do_instr(4'h9, 0, 1'b0, 2, 1'b1);
    do_reset();
    do_instr(4'h6, 0, 1'b0, 0, 1'b0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
